// File: rtl/game_pkg.sv
// game_pkg: state encodings, output widths and BCD increment shared by the game logic.
package game_pkg;
  localparam int SCORE_W = 8;
  localparam int LIVES_W = 2;
  localparam int CD_W = 2;
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_HURT      = 3'd3,
    S_OVER      = 3'd4
  } state_t;
  function automatic logic [7:0] bcd_inc(input logic [7:0] b);
    return b[3:0] == 4'd9 ? {b[7:4] + 4'd1, 4'd0} : {b[7:4], b[3:0] + 4'd1};
  endfunction
endpackage

// File: rtl/frame_div.sv
// frame_div: counts enabled frame ticks and flags the tick on which the count wraps at N.
module frame_div #(
  parameter int N = 60
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic wrap
);
  localparam int W = N > 1 ? $clog2(N) : 1;
  logic [W-1:0] cnt;
  assign wrap = en && cnt == W'(N - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr || wrap) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/frame_tick.sv
// frame_tick: VSync falling-edge frame tick plus the countdown and hurt frame dividers.
module frame_tick #(
  parameter int FRAMES_PER_SEC = 60,
  parameter int HURT_FRAMES = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  input  logic cd_clr,
  input  logic cd_run,
  input  logic hurt_clr,
  input  logic hurt_run,
  output logic tick,
  output logic cd_wrap,
  output logic hurt_wrap
);
  logic vsync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vsync_q <= 1'b0;
      tick <= 1'b0;
    end else begin
      vsync_q <= vsync;
      tick <= vsync_q & ~vsync;
    end
  frame_div #(.N(FRAMES_PER_SEC)) u_cd (
    .clk(clk), .rst_n(rst_n), .clr(cd_clr), .en(cd_run & tick), .wrap(cd_wrap)
  );
  frame_div #(.N(HURT_FRAMES)) u_hurt (
    .clk(clk), .rst_n(rst_n), .clr(hurt_clr), .en(hurt_run & tick), .wrap(hurt_wrap)
  );
endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: frame-synchronous game sequencer owning state, score (binary and BCD),
// lives and countdown; the frame tick and timers live in frame_tick.
module game_ctrl
  import game_pkg::*;
#(
  parameter int FRAMES_PER_SEC = 60,
  parameter int COUNTDOWN_SEC = 3,
  parameter int LIVES = 3,
  parameter int MAX_SCORE = 99,
  parameter int HURT_FRAMES = 30
) (
  input  logic               i_Clk,
  input  logic               i_Rst_N,
  input  logic               i_VSync,
  input  logic               i_Start,
  input  logic               i_Collect,
  input  logic               i_Hit,
  output logic [2:0]         o_State,
  output logic               o_Play_En,
  output logic               o_Frame_Tick,
  output logic [SCORE_W-1:0] o_Score,
  output logic [7:0]         o_Score_BCD,
  output logic [LIVES_W-1:0] o_Lives,
  output logic [CD_W-1:0]    o_Countdown,
  output logic               o_Game_Over
);
  state_t state;
  logic start_q, start_edge, launch, playing, score_up, cd_wrap, hurt_wrap;
  assign o_State = state;
  assign start_edge = i_Start & ~start_q;
  assign launch = start_edge && (state == S_IDLE || state == S_OVER);
  assign playing = state == S_PLAY || state == S_HURT;
  assign score_up = i_Collect && playing && o_Score != SCORE_W'(MAX_SCORE);
  frame_tick #(.FRAMES_PER_SEC(FRAMES_PER_SEC), .HURT_FRAMES(HURT_FRAMES)) u_tick (
    .clk(i_Clk), .rst_n(i_Rst_N), .vsync(i_VSync),
    .cd_clr(launch), .cd_run(state == S_COUNTDOWN),
    .hurt_clr(state == S_PLAY && i_Hit), .hurt_run(state == S_HURT),
    .tick(o_Frame_Tick), .cd_wrap(cd_wrap), .hurt_wrap(hurt_wrap)
  );
  always_ff @(posedge i_Clk or negedge i_Rst_N)
    if (!i_Rst_N) begin
      state <= S_IDLE;
      start_q <= 1'b0;
      o_Play_En <= 1'b0;
      o_Score <= '0;
      o_Score_BCD <= '0;
      o_Lives <= '0;
      o_Countdown <= '0;
      o_Game_Over <= 1'b0;
    end else begin
      start_q <= i_Start;
      if (score_up) begin
        o_Score <= o_Score + 1'b1;
        o_Score_BCD <= bcd_inc(o_Score_BCD);
      end
      case (state)
        S_IDLE, S_OVER:
          if (start_edge) begin
            state <= S_COUNTDOWN;
            o_Score <= '0;
            o_Score_BCD <= '0;
            o_Lives <= LIVES_W'(LIVES);
            o_Countdown <= CD_W'(COUNTDOWN_SEC);
            o_Play_En <= 1'b0;
            o_Game_Over <= 1'b0;
          end
        S_COUNTDOWN:
          if (cd_wrap) begin
            o_Countdown <= o_Countdown - 1'b1;
            if (o_Countdown == CD_W'(1)) begin
              state <= S_PLAY;
              o_Play_En <= 1'b1;
            end
          end
        S_PLAY:
          if (i_Hit) begin
            o_Lives <= o_Lives - 1'b1;
            // a fatal hit still lets a same-cycle collect score
            if (o_Lives == LIVES_W'(1)) begin
              state <= S_OVER;
              o_Play_En <= 1'b0;
              o_Game_Over <= 1'b1;
            end else state <= S_HURT;
          end
        S_HURT: if (hurt_wrap) state <= S_PLAY;
        default: begin
          state <= S_IDLE;
          o_Play_En <= 1'b0;
          o_Game_Over <= 1'b0;
          o_Countdown <= '0;
        end
      endcase
    end
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed and random stimulus against a tick-counting reference model,
// with a scoreboard queue popped by an independent output monitor.
module tb_game_ctrl;
  localparam int FPS = 2, CD = 3, LV = 2, HF = 3, MAXS = 12;
  logic clk = 0, rst_n = 0, vsync = 0, start = 0, collect = 0, hit = 0;
  logic [2:0] state;
  logic play_en, ftick, game_over;
  logic [7:0] score, bcd;
  logic [1:0] lives, countdown;
  int passed = 0, total = 0, fcnt = 0;
  int ph, sc, lv, cdt, ht;
  bit m_vsq, m_tick, m_stq;
  logic [25:0] sb[$];

  game_ctrl #(.FRAMES_PER_SEC(FPS), .COUNTDOWN_SEC(CD), .LIVES(LV), .MAX_SCORE(MAXS),
              .HURT_FRAMES(HF)) dut (
    .i_Clk(clk), .i_Rst_N(rst_n), .i_VSync(vsync), .i_Start(start), .i_Collect(collect),
    .i_Hit(hit), .o_State(state), .o_Play_En(play_en), .o_Frame_Tick(ftick),
    .o_Score(score), .o_Score_BCD(bcd), .o_Lives(lives), .o_Countdown(countdown),
    .o_Game_Over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [25:0] dut_vec();
    return {state, play_en, ftick, score, bcd, lives, countdown, game_over};
  endfunction

  function automatic logic [25:0] model_vec();
    logic [7:0] b;
    b = 8'((sc / 10) * 16 + sc % 10);
    return {3'(ph), ph == 2 || ph == 3, m_tick, 8'(sc), b, 2'(lv),
            2'(ph == 1 ? CD - cdt / FPS : 0), ph == 4};
  endfunction

  task automatic model_reset();
    ph = 0; sc = 0; lv = 0; cdt = 0; ht = 0;
    m_vsq = 0; m_tick = 0; m_stq = 0;
  endtask

  // One clock of game rules: totals of elapsed ticks decide countdown and hurt exits.
  task automatic model_step();
    bit t, se;
    t = m_tick;
    se = start && !m_stq;
    m_tick = m_vsq && !vsync;
    m_vsq = vsync;
    m_stq = start;
    case (ph)
      0, 4: if (se) begin ph = 1; sc = 0; lv = LV; cdt = 0; end
      1: if (t) begin cdt++; if (cdt == CD * FPS) ph = 2; end
      2: begin
        if (collect && sc < MAXS) sc++;
        if (hit) begin lv--; ph = lv == 0 ? 4 : 3; ht = 0; end
      end
      3: begin
        if (collect && sc < MAXS) sc++;
        if (t) begin ht++; if (ht == HF) ph = 2; end
      end
      default: ph = 0;
    endcase
  endtask

  task automatic cyc(input bit s, input bit c, input bit h);
    @(negedge clk);
    fcnt = (fcnt + 1) % 8;
    vsync = fcnt < 6;
    start = s; collect = c; hit = h;
    model_step();
    sb.push_back(model_vec());
  endtask

  task automatic peek();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_phase(input int p, input bit s);
    int n = 0;
    while (ph != p && n < 300) begin cyc(s, 0, 0); n++; end
    check("reach_phase", 32'(ph), 32'(p));
  endtask

  task automatic check_reset(input string nm);
    check({nm, "_state"}, 32'(state), 0);
    check({nm, "_play"}, 32'(play_en), 0);
    check({nm, "_tick"}, 32'(ftick), 0);
    check({nm, "_score"}, 32'(score), 0);
    check({nm, "_bcd"}, 32'(bcd), 0);
    check({nm, "_lives"}, 32'(lives), 0);
    check({nm, "_cd"}, 32'(countdown), 0);
    check({nm, "_over"}, 32'(game_over), 0);
  endtask

  initial forever begin
    logic [25:0] e;
    @(posedge clk);
    #1;
    if (rst_n && sb.size() > 0) begin
      e = sb.pop_front();
      check("outputs", 32'(dut_vec()), 32'(e));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    #3 check_reset("rst");
    @(posedge clk);
    #2 rst_n = 1;
    cyc(1, 0, 0);
    peek();
    check("start_state", 32'(state), 1);
    check("start_cd", 32'(countdown), 3);
    check("start_lives", 32'(lives), 2);
    wait_phase(2, 1);
    peek();
    check("play_en", 32'(play_en), 1);
    check("play_cd", 32'(countdown), 0);
    cyc(1, 0, 1);
    cyc(1, 0, 1);
    peek();
    check("hurt_state", 32'(state), 3);
    check("hurt_lives", 32'(lives), 1);
    wait_phase(2, 1);
    cyc(1, 1, 1);
    peek();
    check("fatal_score", 32'(score), 1);
    check("fatal_lives", 32'(lives), 0);
    check("fatal_over", 32'(game_over), 1);
    check("fatal_play", 32'(play_en), 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    peek();
    check("restart_state", 32'(state), 1);
    check("restart_score", 32'(score), 0);
    check("restart_lives", 32'(lives), 2);
    wait_phase(2, 1);
    for (int i = 0; i < 13; i++) begin cyc(1, 1, 0); cyc(1, 0, 0); end
    peek();
    check("sat_score", 32'(score), 12);
    check("sat_bcd", 32'(bcd), 32'h12);
    cyc(1, 0, 1);
    cyc(0, 0, 0);
    check("mid_hurt", 32'(ph), 3);
    @(negedge clk);
    #2 rst_n = 0;
    #1 check_reset("async");
    sb.delete();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1;
    for (int i = 0; i < 900; i++)
      cyc($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0);
    cyc(0, 0, 0);
    peek();
    check("drain", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
